// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared core definitions used by the data-cache port arbiter:
//   u32_t          - 32-bit data/address word
//   dc_arb_state_t - arbiter FSM states (IDLE, REQ, WAIT, DROP)
//   dc_owner_t     - owner of the in-flight transaction (PIPE, AUX)
//   dcache_req_t   - request fields presented to the dcache
// ---------------------------------------------------------------------------
package cpu_defs;

    typedef logic [31:0] u32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } dc_arb_state_t;

    typedef enum logic {
        PIPE = 1'b0,
        AUX  = 1'b1
    } dc_owner_t;

    typedef struct packed {
        logic       we;
        u32_t       addr;
        u32_t       wdata;
        logic [3:0] wstrb;
    } dcache_req_t;

    // Bit positions of the one-hot grant vector produced by the picker.
    localparam int unsigned GNT_PIPE = 0;
    localparam int unsigned GNT_AUX  = 1;

endpackage

// File: rtl/dc_arb_pick.sv
// ---------------------------------------------------------------------------
// dc_arb_pick
// Combinational two-way picker for the dcache port arbiter.
// Configuration macro: DCACHE_ARB_RR_EN
//   defined   - round-robin: on a tie, the requester that is not last_owner wins
//   undefined - fixed priority, pipeline first (last_owner port is absent)
// Ports:
//   pipe_req   in  effective pipeline request (already flush-masked)
//   aux_req    in  auxiliary request
//   last_owner in  owner of the most recent grant (round-robin build only)
//   gnt        out one-hot grant, bit GNT_PIPE / GNT_AUX
// ---------------------------------------------------------------------------
module dc_arb_pick
    import cpu_defs::*;
(
    input  logic       pipe_req,
    input  logic       aux_req,
`ifdef DCACHE_ARB_RR_EN
    input  dc_owner_t  last_owner,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (pipe_req && aux_req) begin
`ifdef DCACHE_ARB_RR_EN
            // Alternate on contention so neither side can starve the other.
            if (last_owner == PIPE) begin
                gnt[GNT_AUX] = 1'b1;
            end else begin
                gnt[GNT_PIPE] = 1'b1;
            end
`else
            gnt[GNT_PIPE] = 1'b1;
`endif
        end else if (pipe_req) begin
            gnt[GNT_PIPE] = 1'b1;
        end else if (aux_req) begin
            gnt[GNT_AUX] = 1'b1;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// ---------------------------------------------------------------------------
// dcache_port_arbiter
// Shares the single data-cache request port between the pipeline memory
// stage and an auxiliary requester (cache maintenance / page walk). One
// transaction is outstanding at a time; its response is routed back to the
// owner. Pipeline transactions are squashed on flush, and a response still
// in flight for a squashed request is swallowed.
// Configuration macro: DCACHE_ARB_RR_EN (round-robin when defined, fixed
// pipeline-first priority otherwise).
// Ports:
//   clk, rst_n                     core clock, async active-low reset
//   flush                          pipeline flush (pipe-owned work only)
//   pipe_req/we/addr/wdata/wstrb   pipeline request (held until pipe_gnt)
//   pipe_gnt                       combinational grant, IDLE only
//   pipe_ready, pipe_rdata         response pulse and data for the pipeline
//   aux_*                          same set for the auxiliary requester
//   dc_req/we/addr/wdata/wstrb     registered request to the dcache
//   dc_gnt                         dcache accepts dc_req
//   dc_ready, dc_rdata             dcache response
// ---------------------------------------------------------------------------
module dcache_port_arbiter
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,

    input  logic       pipe_req,
    input  logic       pipe_we,
    input  u32_t       pipe_addr,
    input  u32_t       pipe_wdata,
    input  logic [3:0] pipe_wstrb,
    output logic       pipe_gnt,
    output logic       pipe_ready,
    output u32_t       pipe_rdata,

    input  logic       aux_req,
    input  logic       aux_we,
    input  u32_t       aux_addr,
    input  u32_t       aux_wdata,
    input  logic [3:0] aux_wstrb,
    output logic       aux_gnt,
    output logic       aux_ready,
    output u32_t       aux_rdata,

    output logic       dc_req,
    output logic       dc_we,
    output u32_t       dc_addr,
    output u32_t       dc_wdata,
    output logic [3:0] dc_wstrb,
    input  logic       dc_gnt,
    input  logic       dc_ready,
    input  u32_t       dc_rdata
);

    dc_arb_state_t state;
    dc_owner_t     owner;
    dcache_req_t   req_q;
    dcache_req_t   sel_req;
    logic [1:0]    pick_gnt;
    logic          pipe_eff;
    logic          pipe_flush;

    // A flushed pipeline request must never win arbitration.
    assign pipe_eff   = pipe_req & ~flush;
    assign pipe_flush = (owner == PIPE) & flush;

`ifdef DCACHE_ARB_RR_EN
    dc_owner_t last_owner;

    // Reset to AUX so the pipeline wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= AUX;
        end else if (pipe_gnt || aux_gnt) begin
            last_owner <= aux_gnt ? AUX : PIPE;
        end
    end

    dc_arb_pick u_pick (
        .pipe_req   (pipe_eff),
        .aux_req    (aux_req),
        .last_owner (last_owner),
        .gnt        (pick_gnt)
    );
`else
    dc_arb_pick u_pick (
        .pipe_req   (pipe_eff),
        .aux_req    (aux_req),
        .gnt        (pick_gnt)
    );
`endif

    // Grants exist only in IDLE; the picker itself is state-agnostic.
    assign pipe_gnt = (state == IDLE) & pick_gnt[GNT_PIPE];
    assign aux_gnt  = (state == IDLE) & pick_gnt[GNT_AUX];

    // A pipeline response arriving together with flush is discarded.
    assign pipe_ready = (state == WAIT) & dc_ready & (owner == PIPE) & ~flush;
    assign aux_ready  = (state == WAIT) & dc_ready & (owner == AUX);
    assign pipe_rdata = dc_rdata;
    assign aux_rdata  = dc_rdata;

    always_comb begin
        sel_req = '0;
        if (aux_gnt) begin
            sel_req.we    = aux_we;
            sel_req.addr  = aux_addr;
            sel_req.wdata = aux_wdata;
            sel_req.wstrb = aux_wstrb;
        end else begin
            sel_req.we    = pipe_we;
            sel_req.addr  = pipe_addr;
            sel_req.wdata = pipe_wdata;
            sel_req.wstrb = pipe_wstrb;
        end
    end

    assign dc_we    = req_q.we;
    assign dc_addr  = req_q.addr;
    assign dc_wdata = req_q.wdata;
    assign dc_wstrb = req_q.wstrb;

    // Transaction FSM. DROP covers an accepted pipeline request whose
    // response must still be absorbed before the port can be reused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= PIPE;
            dc_req <= 1'b0;
            req_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pipe_gnt || aux_gnt) begin
                        req_q  <= sel_req;
                        owner  <= aux_gnt ? AUX : PIPE;
                        dc_req <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (dc_gnt) begin
                        dc_req <= 1'b0;
                        state  <= pipe_flush ? DROP : WAIT;
                    end else if (pipe_flush) begin
                        // Withdrawn before the cache saw it: nothing to drain.
                        dc_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WAIT: begin
                    if (dc_ready) begin
                        state <= IDLE;
                    end else if (pipe_flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (dc_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    dc_req <= 1'b0;
                end
            endcase
        end
    end

    // A response with no accepted request outstanding is a cache protocol error.
    a_no_stray_ready : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(dc_ready && ((state == IDLE) || (state == REQ)))
    );

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Arbitrates the single data-cache request port between two requesters: the pipeline memory stage (loads/stores from Memory1) and an auxiliary requester (cache-maintenance or page-walk unit). It allows one outstanding transaction at a time and routes each response back to its owner. Pipeline transactions are squashed on flush, and responses already in flight for them are swallowed. It sits between Memory1/aux logic and the dcache; its `pipe_ready` feeds the Memory2 stall logic.

## Interface
- No parameters; widths come from the shared package (`u32_t`, 4-bit strobe).
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `flush`  in  1  pipeline flush; kills pipeline-side transactions only.
- `pipe_req`  in  1  pipeline request valid; held until `pipe_gnt`.
- `pipe_we`  in  1  store when 1.
- `pipe_addr`, `pipe_wdata`  in  32  address / store data.
- `pipe_wstrb`  in  4  byte strobe.
- `pipe_gnt`  out  1  request latched this cycle.
- `pipe_ready`  out  1  response for pipeline (1-cycle pulse).
- `pipe_rdata`  out  32  load data, valid with `pipe_ready`.
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_wstrb`, `aux_gnt`, `aux_ready`, `aux_rdata`: same meaning for the aux requester.
- `dc_req`  out  1  request to dcache (registered).
- `dc_we`, `dc_addr`, `dc_wdata`, `dc_wstrb`  out  1/32/32/4  registered request fields.
- `dc_gnt`  in  1  dcache accepts `dc_req` this cycle.
- `dc_ready`  in  1  dcache response valid.
- `dc_rdata`  in  32  response data.

## Operation
- **State machine:**
  - IDLE: no transaction.
  - REQ: `dc_req` is presented.
  - WAIT: request accepted, awaiting the response.
  - DROP: request accepted, but the response will be discarded.
- **IDLE**
  - Effective pipe request is `pipe_req & ~flush`.
  - If exactly one requester is active, grant it.
  - If both are active, apply the arbitration policy (see Configuration).
  - The grant is a combinational `*_gnt` pulse in the same cycle.
  - The request fields are latched into the `dc_*` registers, `owner` is recorded, and the FSM goes to REQ.
- **REQ**
  - `dc_req=1` with stable fields until `dc_gnt`.
  - On `dc_gnt`: go to WAIT, or to DROP if `owner==PIPE & flush` in the same cycle.
  - If `owner==PIPE & flush & ~dc_gnt`: go to IDLE with `dc_req` deasserted next cycle. The request is withdrawn and never reaches the cache.
- **WAIT**
  - On `dc_ready`: pulse `owner_ready` with `rdata=dc_rdata` and go to IDLE.
  - Exception: if `owner==PIPE & flush` in the same cycle, the response is discarded (no `pipe_ready`) and the FSM goes to IDLE.
  - If `owner==PIPE & flush` without `dc_ready`: go to DROP.
- **DROP**
  - Ignore `flush`.
  - On `dc_ready`: go to IDLE without any ready pulse.
- **Flush scope:** a flush never affects an aux-owned transaction. Accepted pipeline stores complete in the cache; squashing them is upstream's responsibility (stores must not be issued speculatively).
- **Grant timing:** no grant is issued outside IDLE. A new grant is possible in the cycle after the return to IDLE.
- **Response routing:** `pipe_rdata`/`aux_rdata` equal `dc_rdata` continuously; consumers qualify with `*_ready`.
- **Unexpected response:** `dc_ready` in IDLE or REQ is a protocol error; it is ignored and checked by an assertion.

## Timing
- **Reset values:**
  - state=IDLE; `dc_req`/`dc_we`=0; `dc_addr`/`dc_wdata`=0; `dc_wstrb`=0.
  - `owner`=PIPE; `last_owner`=AUX, so pipe wins the first tie.
  - All `*_gnt`/`*_ready` outputs are 0.
- **Request latency:** `*_req` at cycle N → `dc_req` at N+1.
- **Response latency:** `dc_ready` at cycle M → `*_ready` at M (combinational pass-through). Minimum turnaround between grants is 3 cycles, with `dc_gnt` and `dc_ready` each arriving on their first cycle.
- **Reset mid-transaction:** return to IDLE immediately. The dcache is reset by the same `rst_n`, so no response is pending afterwards.

## Configuration
- `DCACHE_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, grant the requester that is not `last_owner`.
  - `last_owner` updates on every grant.
- `DCACHE_ARB_RR_EN` undefined: fixed priority, pipeline first. `last_owner` logic is removed, and aux waits until `pipe_req` is low in IDLE.

## Structure
- **Shared package (`cpu_defs`):**
  - `dc_arb_state_t` enum {IDLE, REQ, WAIT, DROP}.
  - `dc_owner_t` enum {PIPE, AUX}.
  - `dcache_req_t` struct {we, addr, wdata, wstrb}.
- **Sub-module:** `dc_arb_pick`, a combinational two-way picker (round-robin or fixed under the macro), outputs one-hot grant. It is the only natural sub-module.

## Test plan
- **Single pipe load:** `pipe_req`, addr=0x1000; `dc_gnt` at +1, `dc_ready` at +3 with 0xDEADBEEF → `pipe_gnt` at 0; `dc_req` cycles 1 only; `pipe_ready`=1 at cycle 3 with `pipe_rdata`=0xDEADBEEF; `aux_ready` stays 0.
- **Simultaneous requests:**
  - Stimulus: pipe and aux both requesting continuously.
  - With `DCACHE_ARB_RR_EN`, grant order is PIPE, AUX, PIPE, AUX.
  - Without the macro, PIPE every time and `aux_gnt` never asserts.
- **Flush in REQ before `dc_gnt`:** pipe request latched, `flush` while `dc_gnt`=0 → `dc_req` low next cycle, state IDLE, no `pipe_ready`; a subsequent `dc_ready` never occurs.
- **Flush in WAIT:** `flush` 1 cycle after `dc_gnt`, `dc_ready` 4 cycles later → state DROP, no `pipe_ready`, next grant possible the cycle after `dc_ready`.
- **Flush with aux owner:** aux transaction in WAIT, `flush` pulses → `aux_ready` still asserts with correct data.
- **Reset mid-WAIT:** `rst_n` low → `dc_req`=0 and state IDLE immediately (asynchronous); after release, a pipe request is granted in the first cycle.
